bcd_add_fnd_scan: RTL and testbench
===================================

Name: bcd_add_fnd_scan

Overview:
- Parametrised multi-digit BCD adder with a multiplexed 7-segment (FND) display driver.
- Adds two DIGITS-wide packed-BCD operands digit-serially, one digit per clock, under a start/busy/done handshake.
- Flags invalid BCD input and holds the (DIGITS+1)-digit result.
- Continuously scans the result onto one shared segment bus with leading-zero blanking; it is the successor to the existing two-digit combinational adder/FND block.

Parameters:
- DIGITS, 4: operand digit count; the result has DIGITS+1 digits, with the top digit being the carry.
- SCAN_DIV, 1000: clock cycles each display position stays active; legal range is 1 or more.
- BLANK_LZ, 1: 1 blanks leading zero digits; position 0 is never blanked.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request an addition; sampled only when idle.
- a  input  4*DIGITS  operand A, packed BCD, digit 0 in bits [3:0].
- b  input  4*DIGITS  operand B, packed BCD.
- busy  output  1  high while an addition is in progress.
- done  output  1  one-cycle pulse when result and err update.
- err  output  1  last completed addition had a digit greater than 9 in a or b.
- result  output  4*(DIGITS+1)  packed BCD sum; the top digit is 0 or 1.
- seg  output  8  segments {dp,g,f,e,d,c,b,a}, active high.
- an  output  DIGITS+1  digit enables, one-hot, active low; bit i selects result digit i.

Behaviour:
- Reset (rst_n low, asynchronous) forces: busy=0, done=0, err=0, result=0, scan prescaler=0, scan position=0, an=~1, seg=8'h3F. Internal FSM goes to IDLE.
- FSM states are IDLE, ADD and FIN.
- IDLE:
  - start=1 at an edge latches a and b, clears the carry, sets digit index=0 and busy=1, then goes to ADD.
  - start=0 keeps the FSM in IDLE.
- ADD, one digit per edge:
  - s = a_i + b_i + c.
  - If s>9: d_i=s-10 and c=1. Otherwise d_i=s and c=0.
  - If a_i>9 or b_i>9, the sticky invalid flag is set. Arithmetic still proceeds; the value is discarded.
  - After digit DIGITS-1 the FSM goes to FIN.
- FIN, one edge:
  - If no invalid digit: result={c, d_DIGITS-1..d_0} and err=0.
  - If invalid: result=0 and err=1.
  - done=1 for this cycle only, busy=0, then go to IDLE.
- Latency: start sampled at edge k; done is high in the cycle after edge k+DIGITS+1.
- Back-to-back starts are allowed: start may be high in the done cycle and is accepted at the next edge, since the FSM is then IDLE.
- start while busy is ignored, and a and b are not re-sampled. Operand changes during ADD have no effect.
- result and err hold until the next FIN; the display always shows the held result.
- Scan:
  - The prescaler counts 0..SCAN_DIV-1 and wraps.
  - On wrap the position advances 0,1,...,DIGITS,0.
  - an = ~(1<<position), updated on the same edge as the position.
  - seg is combinational from position, result and err.
- Segment codes for digits 0..9: 3F, 06, 5B, 4F, 66, 6D, 7D, 07, 7F, 6F. Digit values 10..15 (unreachable) produce 00. dp is always 0.
- Blanking (BLANK_LZ=1): position p>0 shows seg=00 when result digit p and all higher digits are 0.
- err=1: every position shows seg=8'h40 (dash), overriding blanking.
- Reset mid-ADD aborts the addition: no done pulse, result stays 0 after release, and the FSM is IDLE.

Test Plan:
- Reset: drive rst_n low asynchronously mid-ADD -> busy, done, err and result are 0 immediately, an=5'b11110, seg=8'h3F; no done pulse after release.
- Basic add, DIGITS=4: a=16'h1234, b=16'h4321, start pulse at edge k -> busy high for edges k+1..k+5, done pulse after edge k+5, result=20'h05555, err=0.
- Full carry ripple: a=16'h9999, b=16'h0001 -> result=20'h10000. Then a=16'h9999, b=16'h9999 -> result=20'h19998.
- Invalid input: a=16'h12A4, b=16'h0001 -> err=1, result=0, seg=8'h40 at every scan position. A following valid add clears err.
- Start while busy: second start pulse 2 cycles after the first, with different operands -> ignored; exactly one done pulse carrying the first sum. Start held high through done -> the next addition begins the cycle after done.
- Scan and blanking, SCAN_DIV=4: result=20'h00042 -> an steps through 11110, 11101, 11011, 10111, 01111 every 4 cycles and wraps. seg reads 5B, 66, 00, 00, 00. With BLANK_LZ=0, positions 2..4 show 3F instead.

Source files
------------

// File: rtl/bcd_add_fnd_scan.sv
// Digit-serial packed-BCD adder with a multiplexed 7-segment display scanner.
// The sum is built one digit per clock. The held result is scanned onto a
// single segment bus, with optional leading-zero blanking and a dash pattern
// shown when the last addition had invalid input.
//
// Handshake: start is sampled only while idle (busy=0). Once accepted, a and b
// are captured and busy stays high until the result is written. done pulses
// for exactly one cycle in the cycle where result and err change. The FSM is
// idle again in that same cycle, so a start held high there is accepted at the
// next edge. A start seen while busy is ignored.
module bcd_add_fnd_scan #(
    parameter int DIGITS   = 4,
    parameter int SCAN_DIV = 1000,
    parameter int BLANK_LZ = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic [4*DIGITS-1:0]       a,
    input  logic [4*DIGITS-1:0]       b,
    output logic                      busy,
    output logic                      done,
    output logic                      err,
    output logic [4*(DIGITS+1)-1:0]   result,
    output logic [7:0]                seg,
    output logic [DIGITS:0]           an,
    output logic [1:0]                dbg_state
);

    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int QW = $clog2(DIGITS + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t              state;
    logic [4*DIGITS-1:0] a_q;
    logic [4*DIGITS-1:0] b_q;
    logic [4*DIGITS-1:0] d_q;
    logic [IW-1:0]       idx;
    logic                carry;
    logic                inv;

    logic [3:0]          a_dig;
    logic [3:0]          b_dig;
    logic [4:0]          sum;
    logic [4:0]          sum_adj;
    logic [3:0]          dig_out;
    logic                carry_out;
    logic                dig_bad;

    logic [PW-1:0]       presc;
    logic [QW-1:0]       pos;
    logic [DIGITS:1]     lz;
    logic [3:0]          cur_dig;
    logic                cur_blank;

    assign dbg_state = state;

    function automatic logic [7:0] seg_code(input logic [3:0] d);
        case (d)
            4'd0:    seg_code = 8'h3F;
            4'd1:    seg_code = 8'h06;
            4'd2:    seg_code = 8'h5B;
            4'd3:    seg_code = 8'h4F;
            4'd4:    seg_code = 8'h66;
            4'd5:    seg_code = 8'h6D;
            4'd6:    seg_code = 8'h7D;
            4'd7:    seg_code = 8'h07;
            4'd8:    seg_code = 8'h7F;
            4'd9:    seg_code = 8'h6F;
            default: seg_code = 8'h00;
        endcase
    endfunction

    // Select the operand digits for the current index and form the decimal digit sum.
    always_comb begin
        a_dig = 4'd0;
        b_dig = 4'd0;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx == IW'(i)) begin
                a_dig = a_q[4*i +: 4];
                b_dig = b_q[4*i +: 4];
            end
        end
        sum       = {1'b0, a_dig} + {1'b0, b_dig} + {4'd0, carry};
        sum_adj   = sum - 5'd10;
        carry_out = (sum > 5'd9);
        dig_out   = carry_out ? sum_adj[3:0] : sum[3:0];
        dig_bad   = (a_dig > 4'd9) || (b_dig > 4'd9);
    end

    // Adder control: capture the operands, add one digit per clock, then publish the result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            err    <= 1'b0;
            result <= '0;
            a_q    <= '0;
            b_q    <= '0;
            d_q    <= '0;
            idx    <= '0;
            carry  <= 1'b0;
            inv    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_q   <= a;
                        b_q   <= b;
                        carry <= 1'b0;
                        inv   <= 1'b0;
                        idx   <= '0;
                        busy  <= 1'b1;
                        state <= ADD;
                    end
                end
                ADD: begin
                    for (int i = 0; i < DIGITS; i++) begin
                        if (idx == IW'(i)) begin
                            d_q[4*i +: 4] <= dig_out;
                        end
                    end
                    carry <= carry_out;
                    if (dig_bad) begin
                        inv <= 1'b1;
                    end
                    if (idx == IW'(DIGITS - 1)) begin
                        state <= FIN;
                    end else begin
                        idx <= idx + IW'(1);
                    end
                end
                FIN: begin
                    // An invalid digit anywhere discards the whole sum.
                    if (inv) begin
                        result <= '0;
                        err    <= 1'b1;
                    end else begin
                        result <= {3'b000, carry, d_q};
                        err    <= 1'b0;
                    end
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Display scan: the prescaler sets the dwell time, and each wrap moves to the next position.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc <= '0;
            pos   <= '0;
            an    <= {{DIGITS{1'b1}}, 1'b0};
        end else begin
            if (presc == PW'(SCAN_DIV - 1)) begin
                presc <= '0;
                // Rotating the active-low one-hot keeps an aligned with pos across the wrap.
                an    <= {an[DIGITS-1:0], an[DIGITS]};
                if (pos == QW'(DIGITS)) begin
                    pos <= '0;
                end else begin
                    pos <= pos + QW'(1);
                end
            end else begin
                presc <= presc + PW'(1);
            end
        end
    end

    // Segment decode for the active position: an error dash wins, then blanking, then the digit.
    always_comb begin
        lz[DIGITS] = (result[4*DIGITS +: 4] == 4'd0);
        for (int i = DIGITS - 1; i >= 1; i--) begin
            lz[i] = lz[i+1] && (result[4*i +: 4] == 4'd0);
        end
        cur_dig   = result[3:0];
        cur_blank = 1'b0;
        for (int i = 1; i <= DIGITS; i++) begin
            if (pos == QW'(i)) begin
                cur_dig   = result[4*i +: 4];
                cur_blank = (BLANK_LZ != 0) && lz[i];
            end
        end
        if (err) begin
            seg = 8'h40;
        end else if (cur_blank) begin
            seg = 8'h00;
        end else begin
            seg = seg_code(cur_dig);
        end
    end

endmodule

// File: tb/tb_bcd_add_fnd_scan.sv
// Bench for bcd_add_fnd_scan with DIGITS=4 and SCAN_DIV=4. One instance has
// leading-zero blanking enabled and a second has it disabled; both share the
// same inputs. The driver pushes each expected sum and its done cycle when it
// issues a start, and the monitor pops and compares on every done pulse.
module tb_bcd_add_fnd_scan;

    localparam int DIGITS   = 4;
    localparam int SCAN_DIV = 4;
    localparam int RW       = 4 * (DIGITS + 1);

    logic              clk   = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [4*DIGITS-1:0] a   = '0;
    logic [4*DIGITS-1:0] b   = '0;

    logic              busy, done, err;
    logic [RW-1:0]     result;
    logic [7:0]        seg;
    logic [DIGITS:0]   an;
    logic [1:0]        dbg_state;

    logic              nb_busy, nb_done, nb_err;
    logic [RW-1:0]     nb_result;
    logic [7:0]        nb_seg;
    logic [DIGITS:0]   nb_an;
    logic [1:0]        nb_dbg_state;

    logic [RW:0]       exp_q[$];
    int                exp_cyc_q[$];
    int                n_tests = 0;
    int                n_fail  = 0;
    int                cyc     = 0;

    bcd_add_fnd_scan #(.DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV), .BLANK_LZ(1)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
        .busy(busy), .done(done), .err(err), .result(result),
        .seg(seg), .an(an), .dbg_state(dbg_state)
    );

    bcd_add_fnd_scan #(.DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV), .BLANK_LZ(0)) dut_nb (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
        .busy(nb_busy), .done(nb_done), .err(nb_err), .result(nb_result),
        .seg(nb_seg), .an(nb_an), .dbg_state(nb_dbg_state)
    );

    // clock / cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // monitor / scoreboard
    always @(negedge clk) begin : monitor
        logic [RW:0] e;
        int          ec;
        if (done) begin
            if (exp_q.size() == 0) begin
                check("no_extra_done", 64'(done), 64'd0);
            end else begin
                e  = exp_q.pop_front();
                ec = exp_cyc_q.pop_front();
                check("sum_result", 64'(result), 64'(e[RW-1:0]));
                check("sum_err", 64'(err), 64'(e[RW]));
                check("done_cycle", 64'(cyc), 64'(ec));
                check("busy_low_at_done", 64'(busy), 64'd0);
                check("nb_done", 64'(nb_done), 64'd1);
                check("nb_result", 64'(nb_result), 64'(e[RW-1:0]));
                check("nb_err", 64'(nb_err), 64'(e[RW]));
            end
        end
    end

    // driver: pulse start for one accepted edge and optionally record the expectation
    task automatic issue(input logic [15:0] va, input logic [15:0] vb,
                         input logic exp_err, input logic [RW-1:0] exp_res, input bit push);
        @(negedge clk);
        a     = va;
        b     = vb;
        start = 1'b1;
        @(posedge clk);
        #1;
        if (push) begin
            exp_q.push_back({exp_err, exp_res});
            exp_cyc_q.push_back(cyc + DIGITS + 1);
        end
        check("busy_after_accept", 64'(busy), 64'd1);
        check("nb_busy_after_accept", 64'(nb_busy), 64'd1);
        start = 1'b0;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 40; i++) begin
            if (exp_q.size() == 0) break;
            @(negedge clk);
        end
        if (exp_q.size() != 0) begin
            check("drain_timeout", 64'(exp_q.size()), 64'd0);
            exp_q.delete();
            exp_cyc_q.delete();
        end
        @(negedge clk);
    endtask

    // scan check: sync to the start of position 0, then walk one full frame
    task automatic scan_check(input logic [39:0] es, input logic [39:0] en);
        logic [DIGITS:0] prev;
        logic [DIGITS:0] ean;
        bit              found;
        int              p;
        found = 1'b0;
        prev  = an;
        for (int i = 0; i < 60 && !found; i++) begin
            @(negedge clk);
            if (an == 5'b11110 && prev == 5'b01111) found = 1'b1;
            else prev = an;
        end
        if (!found) begin
            n_tests++;
            n_fail++;
            $display("FAIL scan_sync: got an=%b, expected a 01111->11110 step", an);
        end else begin
            for (int j = 0; j < 5 * SCAN_DIV; j++) begin
                if (j > 0) @(negedge clk);
                p   = j / SCAN_DIV;
                ean = 5'b00001 << p;
                ean = ~ean;
                check("scan_an", 64'(an), 64'(ean));
                check("scan_nb_an", 64'(nb_an), 64'(ean));
                check("scan_seg", 64'(seg), 64'(es[8*p +: 8]));
                check("scan_nb_seg", 64'(nb_seg), 64'(en[8*p +: 8]));
            end
            @(negedge clk);
            check("scan_wrap_an", 64'(an), 64'(5'b11110));
        end
    endtask

    initial begin
        // reset state
        repeat (2) @(negedge clk);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        check("rst_result", 64'(result), 64'd0);
        check("rst_an", 64'(an), 64'(5'b11110));
        check("rst_seg", 64'(seg), 64'h3F);
        check("rst_state", 64'(dbg_state), 64'd0);
        check("rst_nb_state", 64'(nb_dbg_state), 64'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // basic add, busy held through the digit steps
        issue(16'h1234, 16'h4321, 1'b0, 20'h05555, 1'b1);
        repeat (5) @(negedge clk);
        check("busy_hold", 64'(busy), 64'd1);
        wait_drain();

        // carry ripple
        issue(16'h9999, 16'h0001, 1'b0, 20'h10000, 1'b1);
        wait_drain();
        issue(16'h9999, 16'h9999, 1'b0, 20'h19998, 1'b1);
        wait_drain();

        // invalid digit: dash everywhere, regardless of blanking
        issue(16'h12A4, 16'h0001, 1'b1, 20'h00000, 1'b1);
        wait_drain();
        scan_check({5{8'h40}}, {5{8'h40}});

        // a valid add clears err
        issue(16'h5678, 16'h4444, 1'b0, 20'h10122, 1'b1);
        wait_drain();

        // start while busy is ignored, operand changes during ADD have no effect
        issue(16'h1111, 16'h2222, 1'b0, 20'h03333, 1'b1);
        @(negedge clk);
        @(negedge clk);
        a     = 16'h5555;
        b     = 16'h5555;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a     = 16'h9999;
        b     = 16'h9999;
        wait_drain();
        repeat (10) @(negedge clk);

        // start held high through done: second add accepted the edge after done
        @(negedge clk);
        a     = 16'h0005;
        b     = 16'h0005;
        start = 1'b1;
        @(posedge clk);
        #1;
        exp_q.push_back({1'b0, 20'h00010});
        exp_cyc_q.push_back(cyc + DIGITS + 1);
        a = 16'h0017;
        b = 16'h0025;
        repeat (6) @(negedge clk);
        check("b2b_done_cycle", 64'(done), 64'd1);
        @(posedge clk);
        #1;
        exp_q.push_back({1'b0, 20'h00042});
        exp_cyc_q.push_back(cyc + DIGITS + 1);
        check("b2b_busy", 64'(busy), 64'd1);
        start = 1'b0;
        wait_drain();

        // scan with blanking on and off
        scan_check({8'h00, 8'h00, 8'h00, 8'h66, 8'h5B}, {8'h3F, 8'h3F, 8'h3F, 8'h66, 8'h5B});

        // asynchronous reset mid-ADD
        issue(16'h1234, 16'h4321, 1'b0, 20'h05555, 1'b0);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_done", 64'(done), 64'd0);
        check("mid_rst_err", 64'(err), 64'd0);
        check("mid_rst_result", 64'(result), 64'd0);
        check("mid_rst_an", 64'(an), 64'(5'b11110));
        check("mid_rst_seg", 64'(seg), 64'h3F);
        check("mid_rst_state", 64'(dbg_state), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        check("post_rst_result", 64'(result), 64'd0);
        check("post_rst_busy", 64'(busy), 64'd0);
        check("post_rst_state", 64'(dbg_state), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
